// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the immediate extender: format selects, XLEN choices, skid buffer states.
// Compressed formats exist only when IMM_RVC_EN is defined; their codes stay reserved otherwise.
package HighLevelControl;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  // Fixed encodings so the compressed codes decode as undefined in a non-RVC build.
  typedef enum logic [3:0] {
    Imm11t0 = 4'd0,
    Imm4t0  = 4'd1,
    SType   = 4'd2,
    UType   = 4'd3,
    JType   = 4'd4,
    BType   = 4'd5
`ifdef IMM_RVC_EN
    ,
    CIType  = 4'd6,
    CJType  = 4'd7,
    CBType  = 4'd8
`endif
  } immSrc;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidState_t;

endpackage

// File: rtl/imm_extend_pipe_format.sv
// Combinational immediate formatter (IMM_RVC_EN adds compressed formats); zero latency.
// No backpressure: pure function of Instr/ImmSrc, undefined selects give Imm=0, ImmErr=1.
module imm_format
  import HighLevelControl::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     Instr,
  input  immSrc           ImmSrc,
`ifdef IMM_RVC_EN
  input  logic            IsCompressed,
`endif
  output logic [XLEN-1:0] Imm,
  output logic            ImmErr
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [31:0] val;
  logic        err;
  logic        unused_opcode;

  assign unused_opcode = ^Instr[6:0];

  always_comb begin
    val = 32'd0;
    err = 1'b0;
    case (ImmSrc)
      Imm11t0: val = 32'($signed(Instr[31:20]));
      Imm4t0:  val = 32'(Instr[20 +: SHAMT_W]);
      SType:   val = 32'($signed({Instr[31:25], Instr[11:7]}));
      UType:   val = {Instr[31:12], 12'b0};
      JType:   val = 32'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
      BType:   val = 32'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
`ifdef IMM_RVC_EN
      CIType:  val = 32'($signed({Instr[12], Instr[6:2]}));
      CJType:  val = 32'($signed({Instr[12], Instr[8], Instr[10:9], Instr[6], Instr[7],
                                  Instr[2], Instr[11], Instr[5:3], 1'b0}));
      CBType:  val = 32'($signed({Instr[12], Instr[6:5], Instr[2], Instr[11:10],
                                  Instr[4:3], 1'b0}));
`endif
      default: err = 1'b1;
    endcase
`ifdef IMM_RVC_EN
    // A format whose width disagrees with the instruction length is as bad as an unknown one.
    if ((ImmSrc inside {CIType, CJType, CBType}) != IsCompressed) begin
      val = 32'd0;
      err = 1'b1;
    end
`endif
  end

  assign Imm    = XLEN'($signed(val));
  assign ImmErr = err;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with 2-entry skid buffer (IMM_RVC_EN: compressed formats); 1-cycle latency.
// InReady is registered (low only when both entries are held); Flush empties the buffer.
module imm_extend_pipe
  import HighLevelControl::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instr,
  input  immSrc           ImmSrc,
`ifdef IMM_RVC_EN
  input  logic            IsCompressed,
`endif
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Imm,
  output logic            ImmErr
);

  if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  skidState_t      state;
  logic [XLEN-1:0] head_imm, skid_imm, fmt_imm;
  logic            head_err, skid_err, fmt_err;
  logic            accept, retire;

  imm_format #(.XLEN(XLEN)) u_format (
    .Instr        (Instr),
    .ImmSrc       (ImmSrc),
`ifdef IMM_RVC_EN
    .IsCompressed (IsCompressed),
`endif
    .Imm          (fmt_imm),
    .ImmErr       (fmt_err)
  );

  assign InReady  = (state != FULL);
  assign OutValid = (state != EMPTY);
  assign Imm      = head_imm;
  assign ImmErr   = head_err;
  assign accept   = InValid & InReady;
  assign retire   = OutValid & OutReady;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      head_imm <= '0;
      head_err <= 1'b0;
      skid_imm <= '0;
      skid_err <= 1'b0;
    end else if (Flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head_imm <= fmt_imm;
          head_err <= fmt_err;
          state    <= ONE;
        end
        ONE: begin
          if (accept && retire) begin
            head_imm <= fmt_imm;
            head_err <= fmt_err;
          end else if (accept) begin
            skid_imm <= fmt_imm;
            skid_err <= fmt_err;
            state    <= FULL;
          end else if (retire) begin
            state <= EMPTY;
          end
        end
        FULL: if (retire) begin
          head_imm <= skid_imm;
          head_err <= skid_err;
          state    <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Producer must hold a stalled beat until it is taken, unless the pipe is being flushed.
  a_invalid_held: assert property (@(posedge clk) disable iff (!reset_n)
    (InValid && !InReady && !Flush) |=> InValid);
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench driving XLEN=32 and XLEN=64 instances with shared stimulus.
module tb_imm_extend_pipe;
  import HighLevelControl::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        InValid, Flush, OutReady;
  logic [31:0] Instr;
  immSrc       ImmSrc;
`ifdef IMM_RVC_EN
  logic        IsCompressed;
`endif

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(in_ready32),
    .Instr(Instr), .ImmSrc(ImmSrc),
`ifdef IMM_RVC_EN
    .IsCompressed(IsCompressed),
`endif
    .Flush(Flush), .OutValid(out_valid32), .OutReady(OutReady),
    .Imm(imm32), .ImmErr(err32)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(in_ready64),
    .Instr(Instr), .ImmSrc(ImmSrc),
`ifdef IMM_RVC_EN
    .IsCompressed(IsCompressed),
`endif
    .Flush(Flush), .OutValid(out_valid64), .OutReady(OutReady),
    .Imm(imm64), .ImmErr(err64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic rdy,
                            input logic [31:0] e32, input logic [63:0] e64, input logic e_err);
    chk({tag, ".valid32"}, {63'd0, out_valid32}, {63'd0, v});
    chk({tag, ".valid64"}, {63'd0, out_valid64}, {63'd0, v});
    chk({tag, ".ready32"}, {63'd0, in_ready32}, {63'd0, rdy});
    chk({tag, ".ready64"}, {63'd0, in_ready64}, {63'd0, rdy});
    if (v) begin
      chk({tag, ".imm32"}, {32'd0, imm32}, {32'd0, e32});
      chk({tag, ".imm64"}, imm64, e64);
      chk({tag, ".err32"}, {63'd0, err32}, {63'd0, e_err});
      chk({tag, ".err64"}, {63'd0, err64}, {63'd0, e_err});
    end
  endtask

  // Drive one beat (InReady assumed high), then check the head right after the edge.
  task automatic one_beat(input string tag, input immSrc src, input logic [31:0] ins,
                          input logic [31:0] e32, input logic [63:0] e64, input logic e_err);
    InValid = 1'b1;
    ImmSrc  = src;
    Instr   = ins;
    @(posedge clk); #1;
    InValid = 1'b0;
    expect_out(tag, 1'b1, 1'b1, e32, e64, e_err);
  endtask

  task automatic drive(input immSrc src, input logic [31:0] ins);
    InValid = 1'b1;
    ImmSrc  = src;
    Instr   = ins;
  endtask

  initial begin
    reset_n  = 1'b0;
    InValid  = 1'b0;
    Flush    = 1'b0;
    OutReady = 1'b1;
    Instr    = 32'd0;
    ImmSrc   = Imm11t0;
`ifdef IMM_RVC_EN
    IsCompressed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);
    chk("reset.imm32", {32'd0, imm32}, 64'd0);
    chk("reset.imm64", imm64, 64'd0);
    chk("reset.err32", {63'd0, err32}, 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // Back-to-back format vectors with OutReady=1 (one beat per cycle).
    @(posedge clk); #1;
    one_beat("i11", Imm11t0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    one_beat("b_e63", BType, 32'hFE000E63, 32'hFFFFF7FC, 64'hFFFFFFFF_FFFFF7FC, 1'b0);
    one_beat("b_ee3", BType, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    one_beat("j", JType, 32'h0080006F, 32'h00000008, 64'h00000000_00000008, 1'b0);
    one_beat("u_neg", UType, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
    one_beat("u_pos", UType, 32'h12345037, 32'h12345000, 64'h00000000_12345000, 1'b0);
    one_beat("shamt", Imm4t0, 32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 1'b0);
    one_beat("s", SType, 32'hFE000C23, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
    one_beat("undef_f", immSrc'(4'hF), 32'hFFFFFFFF, 32'd0, 64'd0, 1'b1);
`ifdef IMM_RVC_EN
    IsCompressed = 1'b1;
    one_beat("ci", CIType, 32'h0000107D, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    one_beat("c_mismatch", Imm11t0, 32'hFFF00093, 32'd0, 64'd0, 1'b1);
    IsCompressed = 1'b0;
`else
    one_beat("undef_6", immSrc'(4'h6), 32'hFFFFFFFF, 32'd0, 64'd0, 1'b1);
`endif
    @(posedge clk); #1;
    expect_out("drain", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);

    // Stall: three beats with OutReady=0, then release.
    OutReady = 1'b0;
    drive(Imm11t0, 32'h00100093);
    @(posedge clk); #1;
    expect_out("stall_a", 1'b1, 1'b1, 32'd1, 64'd1, 1'b0);
    drive(Imm11t0, 32'h00200093);
    @(posedge clk); #1;
    expect_out("stall_full", 1'b1, 1'b0, 32'd1, 64'd1, 1'b0);
    drive(Imm11t0, 32'h00300093);
    @(posedge clk); #1;
    expect_out("stall_hold", 1'b1, 1'b0, 32'd1, 64'd1, 1'b0);
    OutReady = 1'b1;
    @(posedge clk); #1;
    expect_out("stall_b", 1'b1, 1'b1, 32'd2, 64'd2, 1'b0);
    @(posedge clk); #1;
    InValid = 1'b0;
    expect_out("stall_c", 1'b1, 1'b1, 32'd3, 64'd3, 1'b0);
    @(posedge clk); #1;
    expect_out("stall_empty", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);

    // Flush while FULL with a beat on the input.
    OutReady = 1'b0;
    drive(Imm11t0, 32'h00400093);
    @(posedge clk); #1;
    drive(Imm11t0, 32'h00500093);
    @(posedge clk); #1;
    expect_out("fl_full", 1'b1, 1'b0, 32'd4, 64'd4, 1'b0);
    drive(Imm11t0, 32'h00600093);
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush   = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    expect_out("flush", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_out("flush_quiet", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);
    end

    // Async reset while FULL.
    OutReady = 1'b0;
    drive(Imm11t0, 32'h00700093);
    @(posedge clk); #1;
    drive(Imm11t0, 32'h00800093);
    @(posedge clk); #1;
    InValid = 1'b0;
    expect_out("rst_full", 1'b1, 1'b0, 32'd7, 64'd7, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);
    chk("rst_async.imm32", {32'd0, imm32}, 64'd0);
    chk("rst_async.imm64", imm64, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    OutReady = 1'b1;
    @(posedge clk); #1;
    one_beat("resume", SType, 32'hFE000C23, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
    @(posedge clk); #1;
    expect_out("resume_empty", 1'b0, 1'b1, 32'd0, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
